// File: rtl/truth_table_sweeper.sv
// Purpose : sweeps {in1,in2,in3} through 000..111 into a 3-input gate, samples the gate's
//           output at the end of each hold window and assembles the 8-bit truth-table word.
// Latency : busy for 8*HOLD_CYCLES cycles after start is accepted, then a one-cycle done.
// Backpressure: none. start is taken only in IDLE or DONE and is ignored while a sweep runs.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start           sweep request (IDLE/DONE only)
//   in1, in2, in3   applied combination (in1 = MSB) to the gate under test
//   out_sample      gate output, synchronous to clk
//   busy            high while a combination is being applied
//   done            one-cycle pulse when the sweep completes
//   table_out       truth-table word, combination 000 in the MSB
//   match           table_out == EXPECTED, valid together with table_out
module truth_table_sweeper #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXPECTED    = 8'h0E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       out_sample,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter value on the last cycle of a hold window.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] table_q, table_d;
    logic       match_q, match_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        match_d = match_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A new sweep discards the previous result.
                    state_d = ST_APPLY;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                    table_d = 8'h00;
                    match_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_APPLY: begin
                if (cnt_q == HOLD_LAST) begin
                    // Combination 000 lands in bit 7 so the word reads like the gate's name.
                    table_d[3'd7 - idx_q] = out_sample;
                    cnt_d = 8'd0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_DONE;
                        // Compare against the word including the bit captured this edge.
                        match_d = (table_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            table_q <= 8'h00;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            match_q <= match_d;
        end
    end

    // All outputs decode from registered state; inputs rest at 000 outside APPLY.
    assign busy            = (state_q == ST_APPLY);
    assign done            = (state_q == ST_DONE);
    assign {in1, in2, in3} = busy ? idx_q : 3'b000;
    assign table_out       = table_q;
    assign match           = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: 0 ideal 0x0E, 1 stuck-0, 2 stuck-1, 3 ideal with 2-cycle lag.
    logic [1:0] mode = 2'd0;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT with HOLD_CYCLES = 4
    logic rst4 = 1'b1, start4 = 1'b0;
    logic a4, b4, c4, os4, busy4, done4, match4;
    logic [7:0] tab4;
    logic f4, l4a, l4b;
    assign f4  = a4 & ~(b4 & c4);
    assign os4 = (mode == 2'd0) ? f4 : (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : l4b;
    always @(posedge clk) begin
        l4a <= f4;
        l4b <= l4a;
    end

    truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(8'h0E)) dut4 (
        .clk(clk), .rst(rst4), .start(start4),
        .in1(a4), .in2(b4), .in3(c4), .out_sample(os4),
        .busy(busy4), .done(done4), .table_out(tab4), .match(match4)
    );

    // DUT with HOLD_CYCLES = 1
    logic rst1 = 1'b1, start1 = 1'b0;
    logic a1, b1, c1, os1, busy1, done1, match1;
    logic [7:0] tab1;
    logic f1, l1a, l1b;
    assign f1  = a1 & ~(b1 & c1);
    assign os1 = (mode == 2'd0) ? f1 : (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : l1b;
    always @(posedge clk) begin
        l1a <= f1;
        l1b <= l1a;
    end

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(8'h0E)) dut1 (
        .clk(clk), .rst(rst1), .start(start1),
        .in1(a1), .in2(b1), .in3(c1), .out_sample(os1),
        .busy(busy1), .done(done1), .table_out(tab1), .match(match1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut4 and step until done (bounded); returns cycles after the accept edge.
    task automatic run4(output int cyc);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 0;
        while (done4 !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic run1(output int cyc);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst4 = 1'b1;
        rst1 = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({a4, b4, c4, busy4, done4, tab4, match4} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_dut4: got %b want all zero", {a4, b4, c4, busy4, done4, tab4, match4});
        end
        n_cmp++;
        if ({a1, b1, c1, busy1, done1, tab1, match1} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_dut1: got %b want all zero", {a1, b1, c1, busy1, done1, tab1, match1});
        end
        rst4 = 1'b0;
        rst1 = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({busy4, done4, busy1, done1} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy/done got %b want 0000", {busy4, done4, busy1, done1});
        end
    endtask

    task automatic test_ideal();
        int cyc;
        int busyc;
        mode = 2'd0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n_cmp++;
        if (busy4 !== 1'b1 || {a4, b4, c4} !== 3'b000) begin
            n_bad++;
            $display("FAIL accept: busy=%b in=%b want busy=1 in=000", busy4, {a4, b4, c4});
        end
        cyc = 0;
        busyc = 0;
        while (done4 !== 1'b1 && cyc < 100) begin
            if (busy4 === 1'b1) busyc++;
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc != 32) begin
            n_bad++;
            $display("FAIL ideal_latency: got %0d want 32", cyc);
        end
        n_cmp++;
        if (busyc != 32) begin
            n_bad++;
            $display("FAIL ideal_busy_len: got %0d want 32", busyc);
        end
        n_cmp++;
        if (tab4 !== 8'h0E || match4 !== 1'b1) begin
            n_bad++;
            $display("FAIL ideal_table: table=%h match=%b want 0e/1", tab4, match4);
        end
        n_cmp++;
        if (busy4 !== 1'b0 || {a4, b4, c4} !== 3'b000) begin
            n_bad++;
            $display("FAIL done_outputs: busy=%b in=%b want 0/000", busy4, {a4, b4, c4});
        end
        step();
        n_cmp++;
        if (done4 !== 1'b0 || tab4 !== 8'h0E || match4 !== 1'b1) begin
            n_bad++;
            $display("FAIL after_done: done=%b table=%h match=%b want 0/0e/1", done4, tab4, match4);
        end
    endtask

    task automatic test_stuck();
        int cyc;
        mode = 2'd1;
        run4(cyc);
        n_cmp++;
        if (cyc != 32 || tab4 !== 8'h00 || match4 !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck0: cyc=%0d table=%h match=%b want 32/00/0", cyc, tab4, match4);
        end
        step();
        mode = 2'd2;
        run4(cyc);
        n_cmp++;
        if (cyc != 32 || tab4 !== 8'hFF || match4 !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck1: cyc=%0d table=%h match=%b want 32/ff/0", cyc, tab4, match4);
        end
        step();
    endtask

    task automatic test_lag4();
        int cyc;
        mode = 2'd3;
        repeat (4) step();
        run4(cyc);
        n_cmp++;
        if (cyc != 32 || tab4 !== 8'h0E || match4 !== 1'b1) begin
            n_bad++;
            $display("FAIL lag_h4: cyc=%0d table=%h match=%b want 32/0e/1", cyc, tab4, match4);
        end
        step();
        mode = 2'd0;
    endtask

    task automatic test_start_spam();
        int dones;
        logic [2:0] exp_in;
        mode = 2'd0;
        start4 = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            exp_in = 3'(i / 4);
            n_cmp++;
            if ({a4, b4, c4} !== exp_in || done4 !== 1'b0) begin
                n_bad++;
                $display("FAIL spam_seq[%0d]: in=%b done=%b want %b/0", i, {a4, b4, c4}, done4, exp_in);
            end
            start4 = (i % 3 == 0) ? 1'b1 : 1'b0;
            step();
        end
        start4 = 1'b0;
        n_cmp++;
        if (done4 !== 1'b1 || tab4 !== 8'h0E) begin
            n_bad++;
            $display("FAIL spam_done: done=%b table=%h want 1/0e", done4, tab4);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done4 === 1'b1 || busy4 === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL spam_extra: got %0d extra busy/done cycles want 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int dones;
        mode = 2'd0;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (12) step();
        n_cmp++;
        if ({a4, b4, c4} !== 3'b011) begin
            n_bad++;
            $display("FAIL mid_comb: in=%b want 011", {a4, b4, c4});
        end
        rst4 = 1'b1;
        start4 = 1'b1;
        step();
        rst4 = 1'b0;
        start4 = 1'b0;
        n_cmp++;
        if ({a4, b4, c4, busy4, done4, tab4, match4} !== 13'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want all zero", {a4, b4, c4, busy4, done4, tab4, match4});
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done4 === 1'b1 || busy4 === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got %0d busy/done cycles want 0", dones);
        end
        run4(cyc);
        n_cmp++;
        if (cyc != 32 || tab4 !== 8'h0E || match4 !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_sweep: cyc=%0d table=%h match=%b want 32/0e/1", cyc, tab4, match4);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int dones;
        mode = 2'd0;
        start1 = 1'b1;
        step();
        dones = 0;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (done1 === 1'b1) begin
                dones++;
                n_cmp++;
                if (c % 9 != 8 || tab1 !== 8'h0E || match1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_done: at cycle %0d table=%h match=%b want cycle%%9==8/0e/1", c, tab1, match1);
                end
            end
        end
        n_cmp++;
        if (dones != 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d dones want 3", dones);
        end
        start1 = 1'b0;
        repeat (12) step();
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0/0", busy1, done1);
        end
    endtask

    task automatic test_lag1();
        int cyc;
        mode = 2'd3;
        repeat (4) step();
        run1(cyc);
        n_cmp++;
        if (cyc != 8 || tab1 !== 8'h03 || match1 !== 1'b0) begin
            n_bad++;
            $display("FAIL lag_h1: cyc=%0d table=%h match=%b want 8/03/0", cyc, tab1, match1);
        end
        step();
        mode = 2'd0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_lag4();
        test_start_spam();
        test_reset_mid();
        test_back_to_back();
        test_lag1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
